// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Arbiter FSM states.
  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_LSU = 1'b1
  } wb_state_e;

  // Which producer owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  // One-hot register mask; x0 never appears in the mask.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic en,
                                                   input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en && (rd != '0)) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register.
// Set has priority over clear on the same edge; bit 0 is hardwired low.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RSTa,
  input  logic                  SET_EN,
  input  logic [REG_ADDR_W-1:0] SET_RD,
  input  logic                  CLR_EN,
  input  logic [REG_ADDR_W-1:0] CLR_RD,
  output logic [NUM_REGS-1:0]   BUSY
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first, then OR in the set mask so a same-edge set survives.
  always_comb begin
    busy_d    = (busy_q & ~reg_mask(CLR_EN, CLR_RD)) | reg_mask(SET_EN, SET_RD);
    busy_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign BUSY = busy_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto the single register
// bank write port, with a starvation guard that eventually forces the LSU
// through, and a pending-load scoreboard for decode hazard stalls.
//
// Handshakes: the ALU has no ready; it presents ALU_VALID and is consumed
// every cycle unless ALU_STALL is high, in which case it holds its result and
// ALU_VALID is ignored. The LSU uses valid/ready: a transfer happens on a
// cycle where LSU_VALID & LSU_READY; while LSU_VALID is high without ready,
// LSU_RD/LSU_DATA must stay stable. LSU_READY never depends on LSU_VALID.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RSTa,
  input  logic                  ALU_VALID,
  input  logic [REG_ADDR_W-1:0] ALU_RD,
  input  logic [XLEN-1:0]       ALU_DATA,
  output logic                  ALU_STALL,
  input  logic                  LSU_VALID,
  input  logic [REG_ADDR_W-1:0] LSU_RD,
  input  logic [XLEN-1:0]       LSU_DATA,
  output logic                  LSU_READY,
  input  logic                  ISSUE_VALID,
  input  logic [REG_ADDR_W-1:0] ISSUE_RD,
  output logic [NUM_REGS-1:0]   BUSY,
  output logic                  WRITE_ENABLE,
  output logic [REG_ADDR_W-1:0] WRITE_REG,
  output logic [XLEN-1:0]       DATA_IN,
  output wb_state_e             STATE_DBG
);

  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  wb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall_q;
  logic                  lsu_ready;
  wb_src_e               src;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  wr_lsu_q;

  // Arbitration, starvation counting and next-state selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lsu_ready = 1'b0;
    src       = SRC_NONE;
    case (state_q)
      NORMAL: begin
        lsu_ready = !ALU_VALID;
        if (ALU_VALID)      src = SRC_ALU;
        else if (LSU_VALID) src = SRC_LSU;
        if (LSU_VALID && !lsu_ready) begin
          if (cnt_q == CNT_W'(STARVE_MAX - 1)) begin
            state_d = FORCE_LSU;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      FORCE_LSU: begin
        // One forced slot; a missing LSU_VALID just returns to NORMAL.
        lsu_ready = 1'b1;
        if (LSU_VALID) src = SRC_LSU;
        state_d = NORMAL;
        cnt_d   = '0;
      end
      default: begin
        state_d = NORMAL;
        cnt_d   = '0;
      end
    endcase
  end

  // Mux the granted result onto the write-port inputs.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    case (src)
      SRC_ALU: begin
        sel_rd   = ALU_RD;
        sel_data = ALU_DATA;
      end
      SRC_LSU: begin
        sel_rd   = LSU_RD;
        sel_data = LSU_DATA;
      end
      default: begin
        sel_rd   = '0;
        sel_data = '0;
      end
    endcase
  end

  // FSM state, starvation counter and the registered ALU stall.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == FORCE_LSU);
    end
  end

  // Write-port registers; address/data hold when nothing is written.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      WRITE_ENABLE <= 1'b0;
      WRITE_REG    <= '0;
      DATA_IN      <= '0;
      wr_lsu_q     <= 1'b0;
    end else if ((src != SRC_NONE) && (sel_rd != '0)) begin
      WRITE_ENABLE <= 1'b1;
      WRITE_REG    <= sel_rd;
      DATA_IN      <= sel_data;
      wr_lsu_q     <= (src == SRC_LSU);
    end else begin
      WRITE_ENABLE <= 1'b0;
      wr_lsu_q     <= 1'b0;
    end
  end

  // Only LSU-sourced writes retire a pending load.
  wb_scoreboard u_scoreboard (
    .CLK    (CLK),
    .RSTa   (RSTa),
    .SET_EN (ISSUE_VALID),
    .SET_RD (ISSUE_RD),
    .CLR_EN (WRITE_ENABLE & wr_lsu_q),
    .CLR_RD (WRITE_REG),
    .BUSY   (BUSY)
  );

  assign LSU_READY = lsu_ready;
  assign ALU_STALL = stall_q;
  assign STATE_DBG = state_q;

endmodule
